// File: rtl/id_regfile_scoreboard_pkg.sv
// Shared widths, the zero-register index and the writeback-match counter
// used by the ID register file and its per-register pending counters.
package id_regfile_scoreboard_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // Upper bounds for the packed arguments of wb_match_count
  localparam int MAX_WR     = 8;
  localparam int MAX_ADDR_W = 8;
  localparam int WB_CNT_W   = 4;

  // Number of enabled writeback ports whose destination equals idx.
  function automatic logic [WB_CNT_W-1:0] wb_match_count(
    input logic [MAX_WR-1:0]            en,
    input logic [MAX_WR*MAX_ADDR_W-1:0] addrs,
    input logic [MAX_ADDR_W-1:0]        idx
  );
    logic [WB_CNT_W-1:0] n;
    n = '0;
    for (int w = 0; w < MAX_WR; w++) begin
      if (en[w] && (addrs[w*MAX_ADDR_W +: MAX_ADDR_W] == idx)) begin
        n = n + WB_CNT_W'(1);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/id_regfile_scoreboard_sb_counter.sv
// One register's pending-write counter: next = cnt + inc - dec, clamped at 0.
// Registered count, 1-cycle update; underflow is a same-cycle pulse.
module sb_counter
  import id_regfile_scoreboard_pkg::*;
#(
  parameter int PEND_W = 2,
  parameter int DEC_W  = WB_CNT_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              inc,
  input  logic [DEC_W-1:0]  dec,
  output logic [PEND_W-1:0] cnt,
  output logic              underflow
);

  localparam int SW = ((PEND_W > DEC_W) ? PEND_W : DEC_W) + 1;

  logic [SW-1:0]     up;
  logic [PEND_W-1:0] cnt_nxt;

  always_comb begin
    up        = SW'(cnt) + SW'(inc);
    underflow = (SW'(dec) > up);
    cnt_nxt   = underflow ? '0 : PEND_W'(up - SW'(dec));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/id_regfile_scoreboard.sv
// Decode register file with writeback bypass and pending-write scoreboard.
// 0-cycle reads; stall is combinational and holds the instruction in decode.
module id_regfile_scoreboard
  import id_regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int PEND_W   = 2
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_need,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     issue_valid,
  input  logic                     issue_we,
  input  logic [ADDR_W-1:0]        issue_dest,
  output logic                     issue_fire,
  output logic                     stall,
  output logic                     sb_error
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]          regs [NUM_REGS];
  logic [PEND_W-1:0]          cnt  [NUM_REGS];
  logic [NUM_REGS-1:0]        uf_vec;
  logic [MAX_WR-1:0]          wr_en_ext;
  logic [MAX_WR*MAX_ADDR_W-1:0] wr_addr_ext;
  logic                       raw_stall;
  logic                       sat_stall;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS);
  endfunction

  always_comb begin
    wr_en_ext   = '0;
    wr_addr_ext = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wr_en_ext[w] = wr_en[w];
      wr_addr_ext[w*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(wr_addr[w*ADDR_W +: ADDR_W]);
    end
  end

  // Later ports override earlier ones, so the highest port index wins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] != ZERO_IDX) &&
            in_range(wr_addr[w*ADDR_W +: ADDR_W])) begin
          regs[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    rd_data = '0;
    a = '0;
    v = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = rd_addr[p*ADDR_W +: ADDR_W];
      v = in_range(a) ? regs[a] : '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == a)) begin
          v = wr_data[w*DATA_W +: DATA_W];
        end
      end
      if (a == ZERO_IDX) begin
        v = '0;
      end
      rd_data[p*DATA_W +: DATA_W] = v;
    end
  end

  // A writeback landing this cycle is bypassed, so it retires its pending slot now.
  always_comb begin
    logic [ADDR_W-1:0] a;
    raw_stall = 1'b0;
    a = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = rd_addr[p*ADDR_W +: ADDR_W];
      if (rd_need[p] && (a != ZERO_IDX) && in_range(a)) begin
        if (int'(cnt[a]) > int'(wb_match_count(wr_en_ext, wr_addr_ext, MAX_ADDR_W'(a)))) begin
          raw_stall = 1'b1;
        end
      end
    end
  end

  // A full counter with a writeback retiring this cycle can still accept one issue.
  always_comb begin
    sat_stall = 1'b0;
    if (issue_valid && issue_we && (issue_dest != ZERO_IDX) && in_range(issue_dest)) begin
      sat_stall = (cnt[issue_dest] == CNT_MAX) &&
                  (wb_match_count(wr_en_ext, wr_addr_ext, MAX_ADDR_W'(issue_dest)) == '0);
    end
  end

  assign stall      = raw_stall | sat_stall;
  assign issue_fire = issue_valid & ~stall;

  assign cnt[0]    = '0;
  assign uf_vec[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    logic [WB_CNT_W-1:0] dec;
    logic                inc;
    assign dec = wb_match_count(wr_en_ext, wr_addr_ext, MAX_ADDR_W'(g));
    assign inc = issue_fire & issue_we & (issue_dest == ADDR_W'(g));
    sb_counter #(
      .PEND_W (PEND_W),
      .DEC_W  (WB_CNT_W)
    ) u_cnt (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .inc       (inc),
      .dec       (dec),
      .cnt       (cnt[g]),
      .underflow (uf_vec[g])
    );
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sb_error <= 1'b0;
    end else if (|uf_vec) begin
      sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Scoreboard bench for id_regfile_scoreboard: a small register/counter model
// predicts every cycle's outputs, queues them, and compares against the DUT.
module tb_id_regfile_scoreboard;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_need;
  logic [63:0] rd_data;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_dest;
  logic        issue_fire;
  logic        stall;
  logic        sb_error;

  logic [4:0]  ra0, ra1, wa0, wa1, idest;
  logic [1:0]  need;
  logic        we0, we1, iv, iwe;
  logic [31:0] wd0, wd1;

  assign rd_addr     = {ra1, ra0};
  assign rd_need     = need;
  assign wr_en       = {we1, we0};
  assign wr_addr     = {wa1, wa0};
  assign wr_data     = {wd1, wd0};
  assign issue_valid = iv;
  assign issue_we    = iwe;
  assign issue_dest  = idest;

  always #5 Clk = ~Clk;

  id_regfile_scoreboard dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .rd_addr     (rd_addr),
    .rd_need     (rd_need),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_dest  (issue_dest),
    .issue_fire  (issue_fire),
    .stall       (stall),
    .sb_error    (sb_error)
  );

  typedef struct {
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        stall;
    logic        fire;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic        m_err;
  logic        m_fire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nwb(input logic [4:0] a);
    return ((we0 && wa0 == a) ? 1 : 0) + ((we1 && wa1 == a) ? 1 : 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = m_regs[a];
    if (we0 && wa0 == a) v = wd0;
    if (we1 && wa1 == a) v = wd1;
    if (a == 5'd0) v = 32'd0;
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'd0;
      m_cnt[r]  = 0;
    end
    m_err  = 1'b0;
    m_fire = 1'b0;
  endtask

  task automatic idle();
    ra0 = 5'd0; ra1 = 5'd0; need = 2'b00;
    we0 = 1'b0; we1 = 1'b0; wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'd0; wd1 = 32'd0;
    iv = 1'b0; iwe = 1'b0; idest = 5'd0;
  endtask

  // Predict this cycle's outputs, queue them, then compare once settled.
  task automatic eval(input string tag);
    exp_t e;
    logic raw, sat;
    e.rd0 = model_read(ra0);
    e.rd1 = model_read(ra1);
    raw = (need[0] && ra0 != 5'd0 && m_cnt[ra0] > nwb(ra0)) ||
          (need[1] && ra1 != 5'd0 && m_cnt[ra1] > nwb(ra1));
    sat = iv && iwe && idest != 5'd0 && (m_cnt[idest] - nwb(idest)) == 3;
    e.stall = raw | sat;
    e.fire  = iv & ~e.stall;
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    m_fire = e.fire;
    check({tag, "/rd0"},   rd_data[31:0],      e.rd0);
    check({tag, "/rd1"},   rd_data[63:32],     e.rd1);
    check({tag, "/stall"}, 32'(stall),         32'(e.stall));
    check({tag, "/fire"},  32'(issue_fire),    32'(e.fire));
  endtask

  // Advance the model and the DUT across one rising edge.
  task automatic commit();
    int v;
    for (int r = 1; r < 32; r++) begin
      v = m_cnt[r] + ((m_fire && iwe && idest == 5'(r)) ? 1 : 0) - nwb(5'(r));
      if (v < 0) begin
        v = 0;
        m_err = 1'b1;
      end
      m_cnt[r] = v;
    end
    if (we0 && wa0 != 5'd0) m_regs[wa0] = wd0;
    if (we1 && wa1 != 5'd0) m_regs[wa1] = wd1;
    @(posedge Clk);
    #1;
    check("sb_error", 32'(sb_error), 32'(m_err));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    model_reset();
    Reset_n = 1'b0;
    #3;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fire",  32'(issue_fire), 32'd0);
    check("rst_rd",    rd_data[31:0], 32'd0);
    check("rst_err",   32'(sb_error), 32'd0);
    @(negedge Clk) Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // r5 written, then wiped by a mid-run reset
    iv = 1'b1; iwe = 1'b1; idest = 5'd5;
    eval("iss_r5"); commit();
    idle(); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    eval("wr_r5"); commit();
    idle(); ra0 = 5'd5;
    eval("rd_r5");
    check("r5_val", rd_data[31:0], 32'hDEADBEEF);
    #1 Reset_n = 1'b0;
    #1;
    check("rst2_r5",    rd_data[31:0], 32'd0);
    check("rst2_stall", 32'(stall), 32'd0);
    check("rst2_err",   32'(sb_error), 32'd0);
    model_reset();
    @(negedge Clk) Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // RAW on r3 resolved by a same-cycle writeback
    idle(); iv = 1'b1; iwe = 1'b1; idest = 5'd3;
    eval("iss_r3");
    check("iss_r3_fire", 32'(issue_fire), 32'd1);
    commit();
    idle(); ra0 = 5'd3; need = 2'b01;
    eval("raw_r3");
    check("raw_r3_stall", 32'(stall), 32'd1);
    commit();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234;
    eval("byp_r3");
    check("byp_r3_stall", 32'(stall), 32'd0);
    check("byp_r3_data",  rd_data[31:0], 32'h1234);
    commit();
    idle(); ra0 = 5'd3; need = 2'b01;
    eval("r3_clear");
    check("r3_clear_stall", 32'(stall), 32'd0);
    commit();

    // Two writebacks to r7 in one cycle, highest port wins
    idle(); iv = 1'b1; iwe = 1'b1; idest = 5'd7;
    eval("iss_r7a"); commit();
    eval("iss_r7b"); commit();
    idle(); ra0 = 5'd7; need = 2'b01;
    eval("r7_pend"); commit();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    eval("r7_dual");
    check("r7_dual_data",  rd_data[31:0], 32'h22);
    check("r7_dual_stall", 32'(stall), 32'd0);
    commit();
    idle(); ra1 = 5'd7; need = 2'b10;
    eval("r7_after");
    check("r7_after_data",  rd_data[63:32], 32'h22);
    check("r7_after_stall", 32'(stall), 32'd0);
    commit();

    // Saturation on r4
    idle(); iv = 1'b1; iwe = 1'b1; idest = 5'd4;
    for (int k = 0; k < 3; k++) begin
      eval("iss_r4"); commit();
    end
    eval("sat_r4");
    check("sat_r4_stall", 32'(stall), 32'd1);
    check("sat_r4_fire",  32'(issue_fire), 32'd0);
    commit();
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h44;
    eval("sat_r4_wb");
    check("sat_r4_wb_fire", 32'(issue_fire), 32'd1);
    commit();
    idle(); we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h45; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h46;
    eval("drain_r4a"); commit();
    we1 = 1'b0;
    eval("drain_r4b"); commit();
    idle(); ra0 = 5'd4; need = 2'b01; iv = 1'b1; iwe = 1'b1; idest = 5'd4;
    eval("r4_free");
    check("r4_free_data", rd_data[31:0], 32'h45);
    commit();
    idle(); we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h47;
    eval("r4_last"); commit();

    // r0 is hardwired, writes and issues to it are ignored
    idle(); ra0 = 5'd0; need = 2'b01; we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF;
    iv = 1'b1; iwe = 1'b1; idest = 5'd0;
    eval("r0");
    check("r0_data",  rd_data[31:0], 32'd0);
    check("r0_stall", 32'(stall), 32'd0);
    commit();

    // Spurious writeback to r9 sets the sticky error
    idle(); we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99;
    eval("wb_r9"); commit();
    check("err_set", 32'(sb_error), 32'd1);
    idle();
    eval("idle"); commit();
    check("err_sticky", 32'(sb_error), 32'd1);
    iv = 1'b1; iwe = 1'b1; idest = 5'd9;
    eval("iss_r9"); commit();
    idle(); ra0 = 5'd9; ra1 = 5'd9; need = 2'b00;
    eval("r9_noneed");
    check("r9_noneed_stall", 32'(stall), 32'd0);
    check("r9_data", rd_data[31:0], 32'h99);
    commit();
    need = 2'b10;
    eval("r9_need");
    check("r9_need_stall", 32'(stall), 32'd1);
    commit();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
